// File: rtl/mips_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mips_ctrl_pkg
//   Shared definitions for the multicycle MIPS main control unit:
//     - state_t      : 4-bit FSM state encoding
//     - OP_*         : opcode field values of the supported instructions
//     - ALUC_*       : ALU operation class handed to the ALU control stage
//     - SRC_B_*      : ALU operand-B mux encodings
//     - op_class_t   : instruction class produced by mips_op_decode
//     - ctrl_t       : registered per-state control word
//     - state_ctrl() : maps a state to its control word
// ---------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_EXEC_R = 4'd3,
        ST_EXEC_I = 4'd4,
        ST_ADDR   = 4'd5,
        ST_MEM_RD = 4'd6,
        ST_MEM_WR = 4'd7,
        ST_WB_R   = 4'd8,
        ST_WB_I   = 4'd9,
        ST_WB_LW  = 4'd10,
        ST_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [2:0] ALUC_RTYPE = 3'b000;
    localparam logic [2:0] ALUC_ADD   = 3'b001;
    localparam logic [2:0] ALUC_AND   = 3'b011;
    localparam logic [2:0] ALUC_OR    = 3'b100;

    localparam logic [1:0] SRC_B_REG  = 2'b00;
    localparam logic [1:0] SRC_B_FOUR = 2'b01;
    localparam logic [1:0] SRC_B_SEXT = 2'b10;
    localparam logic [1:0] SRC_B_ZEXT = 2'b11;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_IALU    = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_JUMP    = 3'd4,
        CLS_ILLEGAL = 3'd5
    } op_class_t;

    // Registered control word. fetch_we and done_on_ready are qualified
    // with the memory handshake in the top level; everything else drives
    // the datapath directly.
    typedef struct packed {
        logic [2:0] aluc;
        logic       pc_we;
        logic       fetch_we;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_we;
        logic       pc_src;
        logic       done;
        logic       done_on_ready;
    } ctrl_t;

    function automatic ctrl_t state_ctrl(input state_t     st,
                                         input logic [2:0] exec_aluc,
                                         input logic [1:0] exec_src_b);
        ctrl_t c;
        c      = '0;
        // ALU class defaults to add so ALU control never sees an
        // undecoded class outside the states that choose one.
        c.aluc = ALUC_ADD;
        case (st)
            ST_IDLE: c = '0;
            ST_FETCH: begin
                c.mem_rd    = 1'b1;
                c.fetch_we  = 1'b1;
                c.alu_src_b = SRC_B_FOUR;
            end
            ST_DECODE: ;
            ST_EXEC_R: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_REG;
                c.aluc      = ALUC_RTYPE;
            end
            ST_EXEC_I: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = exec_src_b;
                c.aluc      = exec_aluc;
            end
            ST_ADDR: begin
                c.alu_src_a = 1'b1;
                c.alu_src_b = SRC_B_SEXT;
            end
            ST_MEM_RD: begin
                c.mem_rd = 1'b1;
                c.iord   = 1'b1;
            end
            ST_MEM_WR: begin
                c.mem_wr        = 1'b1;
                c.iord          = 1'b1;
                c.done_on_ready = 1'b1;
            end
            ST_WB_R: begin
                c.reg_we  = 1'b1;
                c.reg_dst = 1'b1;
                c.done    = 1'b1;
            end
            ST_WB_I: begin
                c.reg_we = 1'b1;
                c.done   = 1'b1;
            end
            ST_WB_LW: begin
                c.reg_we     = 1'b1;
                c.mem_to_reg = 1'b1;
                c.done       = 1'b1;
            end
            ST_JUMP: begin
                c.pc_we  = 1'b1;
                c.pc_src = 1'b1;
                c.done   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mips_op_decode.sv
// ---------------------------------------------------------------------------
// mips_op_decode
//   Combinational opcode decoder for the multicycle control unit.
//   Ports:
//     i_opcode      in  6  opcode field from the instruction register
//     o_op_class    out    instruction class (R, IALU, LOAD, STORE, JUMP,
//                          ILLEGAL)
//     o_exec_aluc   out 3  ALU class used in EXEC_I
//     o_exec_src_b  out 2  ALU operand-B select used in EXEC_I
// ---------------------------------------------------------------------------
module mips_op_decode
    import mips_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    output op_class_t  o_op_class,
    output logic [2:0] o_exec_aluc,
    output logic [1:0] o_exec_src_b
);

    // NOTE: every output gets a default before the case so no path through
    // the block leaves a signal unassigned, which would infer a latch.
    always_comb begin
        o_op_class   = CLS_ILLEGAL;
        o_exec_aluc  = ALUC_ADD;
        o_exec_src_b = SRC_B_SEXT;
        case (i_opcode)
            OP_RTYPE: o_op_class = CLS_R;
            OP_J:     o_op_class = CLS_JUMP;
            OP_LW:    o_op_class = CLS_LOAD;
            OP_SW:    o_op_class = CLS_STORE;
            OP_ADDI: begin
                o_op_class   = CLS_IALU;
                o_exec_aluc  = ALUC_ADD;
                o_exec_src_b = SRC_B_SEXT;
            end
            // Logical immediates are zero-extended.
            OP_ANDI: begin
                o_op_class   = CLS_IALU;
                o_exec_aluc  = ALUC_AND;
                o_exec_src_b = SRC_B_ZEXT;
            end
            OP_ORI: begin
                o_op_class   = CLS_IALU;
                o_exec_aluc  = ALUC_OR;
                o_exec_src_b = SRC_B_ZEXT;
            end
            default: o_op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Multicycle MIPS main control FSM. Steps each instruction through
//   FETCH / DECODE / execute / memory / write-back and drives the datapath
//   strobes, mux selects and the ALU operation class.
//
//   Ports:
//     i_clk         in  1  clock, rising edge
//     i_rst_n       in  1  asynchronous active-low reset
//     i_opcode      in  6  opcode field from the instruction register
//     i_mem_ready   in  1  memory handshake (data valid / write accepted)
//     o_aluc        out 3  ALU class: 000 R-type, 001 add, 011 and, 100 or
//     o_pc_we       out 1  PC write enable
//     o_ir_we       out 1  instruction register write enable
//     o_iord        out 1  memory address select: 0 PC, 1 ALU out register
//     o_mem_rd      out 1  memory read request
//     o_mem_wr      out 1  memory write request
//     o_alu_src_a   out 1  0 PC, 1 register A
//     o_alu_src_b   out 2  00 B, 01 const 4, 10 sign-ext imm, 11 zero-ext imm
//     o_reg_dst     out 1  0 rt, 1 rd
//     o_mem_to_reg  out 1  0 ALU out register, 1 memory data register
//     o_reg_we      out 1  register file write enable
//     o_pc_src      out 1  0 ALU result, 1 jump target
//     o_illegal     out 1  pulse in DECODE on an undefined opcode
//     o_instr_done  out 1  pulse in the final state of every instruction
//
//   Configuration macro: MIPS_CTRL_MEM_WAIT_EN
//     defined   - FETCH, MEM_RD and MEM_WR wait on i_mem_ready.
//     undefined - memory is single-cycle; i_mem_ready is ignored.
// ---------------------------------------------------------------------------
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_opcode,
    input  logic       i_mem_ready,
    output logic [2:0] o_aluc,
    output logic       o_pc_we,
    output logic       o_ir_we,
    output logic       o_iord,
    output logic       o_mem_rd,
    output logic       o_mem_wr,
    output logic       o_alu_src_a,
    output logic [1:0] o_alu_src_b,
    output logic       o_reg_dst,
    output logic       o_mem_to_reg,
    output logic       o_reg_we,
    output logic       o_pc_src,
    output logic       o_illegal,
    output logic       o_instr_done
);

    state_t     state_q;
    state_t     state_d;
    ctrl_t      ctrl_q;
    op_class_t  op_class;
    logic [2:0] exec_aluc;
    logic [1:0] exec_src_b;
    logic       mem_ready;
    logic       illegal;

`ifdef MIPS_CTRL_MEM_WAIT_EN
    assign mem_ready = i_mem_ready;
`else
    // Single-cycle memory: the handshake is treated as always ready.
    logic unused_mem_ready;
    assign unused_mem_ready = i_mem_ready;
    assign mem_ready        = 1'b1;
`endif

    mips_op_decode u_op_decode (
        .i_opcode     (i_opcode),
        .o_op_class   (op_class),
        .o_exec_aluc  (exec_aluc),
        .o_exec_src_b (exec_src_b)
    );

    // Next-state logic. The opcode is stable from DECODE onward, so the
    // decoded class is valid wherever it is consulted below.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (mem_ready) state_d = ST_DECODE;
            ST_DECODE: begin
                case (op_class)
                    CLS_R:                state_d = ST_EXEC_R;
                    CLS_IALU:             state_d = ST_EXEC_I;
                    CLS_LOAD, CLS_STORE:  state_d = ST_ADDR;
                    CLS_JUMP:             state_d = ST_JUMP;
                    default:              state_d = ST_FETCH;
                endcase
            end
            ST_EXEC_R: state_d = ST_WB_R;
            ST_EXEC_I: state_d = ST_WB_I;
            ST_ADDR:   state_d = (op_class == CLS_STORE) ? ST_MEM_WR : ST_MEM_RD;
            ST_MEM_RD: if (mem_ready) state_d = ST_WB_LW;
            ST_MEM_WR: if (mem_ready) state_d = ST_FETCH;
            ST_WB_R,
            ST_WB_I,
            ST_WB_LW,
            ST_JUMP:   state_d = ST_FETCH;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State and control word are registered together: the control word is
    // computed from the state being entered, so outputs are glitch-free
    // flops and clear asynchronously with the state.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= state_ctrl(state_d, exec_aluc, exec_src_b);
        end
    end

    // The opcode is only loaded into the IR at the end of FETCH, so the
    // illegal flag has to come from the live decode while in DECODE.
    assign illegal = (state_q == ST_DECODE) && (op_class == CLS_ILLEGAL);

    // PC and IR are written only on the accepting FETCH cycle so the PC
    // advances exactly once per instruction.
    assign o_ir_we      = ctrl_q.fetch_we & mem_ready;
    assign o_pc_we      = ctrl_q.pc_we | (ctrl_q.fetch_we & mem_ready);
    assign o_instr_done = ctrl_q.done | (ctrl_q.done_on_ready & mem_ready) | illegal;
    assign o_illegal    = illegal;

    assign o_aluc       = ctrl_q.aluc;
    assign o_iord       = ctrl_q.iord;
    assign o_mem_rd     = ctrl_q.mem_rd;
    assign o_mem_wr     = ctrl_q.mem_wr;
    assign o_alu_src_a  = ctrl_q.alu_src_a;
    assign o_alu_src_b  = ctrl_q.alu_src_b;
    assign o_reg_dst    = ctrl_q.reg_dst;
    assign o_mem_to_reg = ctrl_q.mem_to_reg;
    assign o_reg_we     = ctrl_q.reg_we;
    assign o_pc_src     = ctrl_q.pc_src;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips_multicycle_ctrl
//   Directed self-checking bench for mips_multicycle_ctrl. Each cycle the
//   full output bundle is compared against a hand-written expected vector.
//   Vector layout (17 bits, MSB first):
//     aluc[2:0] pc_we ir_we iord mem_rd mem_wr alu_src_a alu_src_b[1:0]
//     reg_dst mem_to_reg reg_we pc_src illegal instr_done
//   Works with MIPS_CTRL_MEM_WAIT_EN defined or undefined.
// ---------------------------------------------------------------------------
module tb_mips_multicycle_ctrl;

    logic       i_clk;
    logic       i_rst_n;
    logic [5:0] i_opcode;
    logic       i_mem_ready;
    logic [2:0] o_aluc;
    logic       o_pc_we;
    logic       o_ir_we;
    logic       o_iord;
    logic       o_mem_rd;
    logic       o_mem_wr;
    logic       o_alu_src_a;
    logic [1:0] o_alu_src_b;
    logic       o_reg_dst;
    logic       o_mem_to_reg;
    logic       o_reg_we;
    logic       o_pc_src;
    logic       o_illegal;
    logic       o_instr_done;

    int n_total = 0;
    int n_bad   = 0;

    mips_multicycle_ctrl dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_opcode     (i_opcode),
        .i_mem_ready  (i_mem_ready),
        .o_aluc       (o_aluc),
        .o_pc_we      (o_pc_we),
        .o_ir_we      (o_ir_we),
        .o_iord       (o_iord),
        .o_mem_rd     (o_mem_rd),
        .o_mem_wr     (o_mem_wr),
        .o_alu_src_a  (o_alu_src_a),
        .o_alu_src_b  (o_alu_src_b),
        .o_reg_dst    (o_reg_dst),
        .o_mem_to_reg (o_mem_to_reg),
        .o_reg_we     (o_reg_we),
        .o_pc_src     (o_pc_src),
        .o_illegal    (o_illegal),
        .o_instr_done (o_instr_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [16:0] obs;
    assign obs = {o_aluc, o_pc_we, o_ir_we, o_iord, o_mem_rd, o_mem_wr,
                  o_alu_src_a, o_alu_src_b, o_reg_dst, o_mem_to_reg,
                  o_reg_we, o_pc_src, o_illegal, o_instr_done};

    //                                aluc   pc ir io rd wr sa sb    rd m2r we ps il dn
    localparam logic [16:0] V_IDLE      = {3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_FETCH_RDY = {3'b001,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_FETCH_W   = {3'b001,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_DECODE    = {3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_DEC_ILL   = {3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1};
    localparam logic [16:0] V_EXEC_R    = {3'b000,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_EXEC_ADDI = {3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_EXEC_ANDI = {3'b011,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_EXEC_ORI  = {3'b100,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b11,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_ADDR      = {3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_MEM_RD    = {3'b001,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_MEM_WR_R  = {3'b001,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1};
    localparam logic [16:0] V_MEM_WR_W  = {3'b001,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0};
    localparam logic [16:0] V_WB_R      = {3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1};
    localparam logic [16:0] V_WB_I      = {3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b1,1'b0,1'b0,1'b1};
    localparam logic [16:0] V_WB_LW     = {3'b001,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b1,1'b1,1'b0,1'b0,1'b1};
    localparam logic [16:0] V_JUMP      = {3'b001,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1};

`ifdef MIPS_CTRL_MEM_WAIT_EN
    // With waits enabled a non-ready FETCH must hold the request without
    // writing PC/IR, and a non-ready MEM_WR is not yet the final cycle.
    localparam logic [16:0] V_FETCH_NR  = V_FETCH_W;
    localparam logic [16:0] V_MEM_WR_NR = V_MEM_WR_W;
    localparam logic        J_READY     = 1'b1;
`else
    localparam logic [16:0] V_FETCH_NR  = V_FETCH_RDY;
    localparam logic [16:0] V_MEM_WR_NR = V_MEM_WR_R;
    localparam logic        J_READY     = 1'b0;
`endif

    task automatic check(input string tag, input logic [16:0] act, input logic [16:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b", tag, act, exp);
        end
    endtask

    // Drive the handshake for the current cycle, compare the outputs, then
    // advance past the next rising edge.
    task automatic expect_cycle(input string tag, input logic rdy, input logic [16:0] exp);
        i_mem_ready = rdy;
        #1;
        check(tag, obs, exp);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst_n     = 1'b0;
        i_opcode    = 6'h00;
        i_mem_ready = 1'b0;
        #2;
        check("reset_outputs", obs, V_IDLE);
        repeat (2) @(posedge i_clk);
        #1;
        check("reset_held", obs, V_IDLE);
        #2;
        i_rst_n = 1'b1;

        // R-type, zero wait states: 4 cycles after IDLE.
        i_opcode = 6'h00;
        expect_cycle("r_idle",   1'b1, V_IDLE);
        expect_cycle("r_fetch",  1'b1, V_FETCH_RDY);
        expect_cycle("r_decode", 1'b1, V_DECODE);
        expect_cycle("r_exec",   1'b1, V_EXEC_R);
        expect_cycle("r_wb",     1'b1, V_WB_R);

        // LW with two FETCH waits and one MEM_RD wait.
        i_opcode = 6'h23;
`ifdef MIPS_CTRL_MEM_WAIT_EN
        expect_cycle("lw_fetch_w1", 1'b0, V_FETCH_W);
        expect_cycle("lw_fetch_w2", 1'b0, V_FETCH_W);
        expect_cycle("lw_fetch",    1'b1, V_FETCH_RDY);
`else
        expect_cycle("lw_fetch",    1'b0, V_FETCH_RDY);
`endif
        expect_cycle("lw_decode", 1'b0, V_DECODE);
        expect_cycle("lw_addr",   1'b1, V_ADDR);
`ifdef MIPS_CTRL_MEM_WAIT_EN
        expect_cycle("lw_memrd_w", 1'b0, V_MEM_RD);
        expect_cycle("lw_memrd",   1'b1, V_MEM_RD);
`else
        expect_cycle("lw_memrd",   1'b0, V_MEM_RD);
`endif
        expect_cycle("lw_wb", 1'b0, V_WB_LW);

        // ORI then ANDI back to back.
        i_opcode = 6'h0D;
        expect_cycle("ori_fetch",  1'b1, V_FETCH_RDY);
        expect_cycle("ori_decode", 1'b1, V_DECODE);
        expect_cycle("ori_exec",   1'b1, V_EXEC_ORI);
        expect_cycle("ori_wb",     1'b1, V_WB_I);
        i_opcode = 6'h0C;
        expect_cycle("andi_fetch",  1'b1, V_FETCH_RDY);
        expect_cycle("andi_decode", 1'b1, V_DECODE);
        expect_cycle("andi_exec",   1'b1, V_EXEC_ANDI);
        expect_cycle("andi_wb",     1'b1, V_WB_I);

        // ADDI uses the sign-extended immediate and add class.
        i_opcode = 6'h08;
        expect_cycle("addi_fetch",  1'b1, V_FETCH_RDY);
        expect_cycle("addi_decode", 1'b1, V_DECODE);
        expect_cycle("addi_exec",   1'b1, V_EXEC_ADDI);
        expect_cycle("addi_wb",     1'b1, V_WB_I);

        // Illegal opcode: 2 cycles, pulse in DECODE, back to FETCH.
        i_opcode = 6'h3F;
        expect_cycle("ill_fetch",  1'b1, V_FETCH_RDY);
        expect_cycle("ill_decode", 1'b1, V_DEC_ILL);

        // Jump: 3 cycles, ready held low when memory waits are disabled.
        i_opcode = 6'h02;
        expect_cycle("j_fetch",  J_READY, V_FETCH_RDY);
        expect_cycle("j_decode", 1'b0, V_DECODE);
        expect_cycle("j_jump",   1'b0, V_JUMP);

        // SW interrupted by reset while in MEM_WR.
        i_opcode = 6'h2B;
        expect_cycle("sw_fetch",  1'b1, V_FETCH_RDY);
        expect_cycle("sw_decode", 1'b1, V_DECODE);
        expect_cycle("sw_addr",   1'b1, V_ADDR);
        i_mem_ready = 1'b0;
        #1;
        check("sw_memwr_pre_rst", obs, V_MEM_WR_NR);
        i_rst_n = 1'b0;
        #1;
        check("sw_rst_async", obs, V_IDLE);
        @(posedge i_clk);
        #1;
        check("sw_rst_held", obs, V_IDLE);
        #1;
        i_rst_n = 1'b1;
        expect_cycle("sw_rst_idle",  1'b1, V_IDLE);
        expect_cycle("sw_fetch2",    1'b1, V_FETCH_RDY);
        expect_cycle("sw_decode2",   1'b1, V_DECODE);
        expect_cycle("sw_addr2",     1'b1, V_ADDR);
        expect_cycle("sw_memwr",     1'b1, V_MEM_WR_R);

        // After the store the next instruction starts in FETCH.
        i_opcode = 6'h00;
        expect_cycle("post_sw_fetch", 1'b1, V_FETCH_RDY);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
